// File: rtl/ifetch_unit.sv
// ifetch_unit: fetch stage between the PC register and decode.
// Issues word reads to a synchronous instruction memory (one-cycle read latency)
// and buffers each returned word with its PC in a DEPTH-entry FIFO. The FIFO
// drains to decode over a valid/ready handshake. A flush discards everything
// fetched so far.
// Optional feature macro: IFETCH_MISALIGN_TRAP_EN. When it is defined, a fetch
// with pc[1]=1 is delivered as a faulting NOP, and issue stalls until a flush.
//
// state       | meaning
// inflight_q  | a read was issued last cycle; its data is on imem_rdata now
// count_q     | number of valid FIFO entries (0..DEPTH)
// halt_q      | misaligned fetch seen; no more issue until flush (trap build only)
module ifetch_unit #(
  parameter int ADDR_W = 13,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [ADDR_W-1:0] pc,
  output logic              pc_en,
  input  logic              flush,
  output logic              imem_req,
  output logic [ADDR_W-3:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [31:0]       id_instr,
  output logic [ADDR_W-1:0] id_pc,
  output logic              id_fault
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0]   DEPTH_OCC = (CW + 1)'(DEPTH);
  localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

  logic              inflight_q, inflight_d;
  logic [ADDR_W-1:0] req_pc_q, req_pc_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [31:0]       instr_q [DEPTH];
  logic [31:0]       instr_d [DEPTH];
  logic [ADDR_W-1:0] pcbuf_q [DEPTH];
  logic [ADDR_W-1:0] pcbuf_d [DEPTH];

  logic [CW:0] occ;
  logic        pop;
  logic        push;
  logic        issue_ok;
  logic [31:0] push_instr;

  assign occ      = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
  assign id_valid = (count_q != '0);
  assign pop      = id_valid & id_ready;
  // A response is written unless a flush in the same cycle discards it.
  assign push     = inflight_q & ~flush;

  // Issuing when occupancy equals DEPTH is safe only if a pop frees a slot this cycle.
  assign imem_req  = rstn & ~flush & issue_ok &
                     ((occ < DEPTH_OCC) | ((occ == DEPTH_OCC) & pop));
  // A flush lets the PC register load the redirect target.
  assign pc_en     = rstn & (imem_req | flush);
  assign imem_addr = pc[ADDR_W-1:2];

  assign id_instr = instr_q[rd_ptr_q];
  assign id_pc    = pcbuf_q[rd_ptr_q];

`ifdef IFETCH_MISALIGN_TRAP_EN
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  logic halt_q, halt_d;
  logic req_fault_q, req_fault_d;
  logic fault_q [DEPTH];
  logic fault_d [DEPTH];

  assign issue_ok   = ~halt_q;
  assign push_instr = req_fault_q ? NOP_INSTR : imem_rdata;
  assign id_fault   = fault_q[rd_ptr_q];

  // Misalign tracking: capture fault with the request, stall issue until flush.
  always_comb begin
    halt_d      = halt_q;
    req_fault_d = req_fault_q;
    fault_d     = fault_q;
    if (flush) begin
      halt_d = 1'b0;
    end else begin
      if (imem_req & pc[1]) halt_d = 1'b1;
      if (push) fault_d[wr_ptr_q] = req_fault_q;
    end
    if (imem_req) req_fault_d = pc[1];
  end

  // Misalign state registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      halt_q      <= 1'b0;
      req_fault_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) fault_q[i] <= 1'b0;
    end else begin
      halt_q      <= halt_d;
      req_fault_q <= req_fault_d;
      fault_q     <= fault_d;
    end
  end
`else
  // pc[1] is ignored; the word at pc[ADDR_W-1:2] is fetched normally.
  assign issue_ok   = 1'b1;
  assign push_instr = imem_rdata;
  assign id_fault   = 1'b0;
`endif

  // Request tracking and FIFO next-state: flush clears, otherwise push/pop.
  always_comb begin
    inflight_d = imem_req;
    req_pc_d   = imem_req ? pc : req_pc_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    instr_d    = instr_q;
    pcbuf_d    = pcbuf_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        instr_d[wr_ptr_q] = push_instr;
        pcbuf_d[wr_ptr_q] = req_pc_q;
        wr_ptr_d          = wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // State registers; reset drops any in-flight data.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      inflight_q <= 1'b0;
      req_pc_q   <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        instr_q[i] <= '0;
        pcbuf_q[i] <= '0;
      end
    end else begin
      inflight_q <= inflight_d;
      req_pc_q   <= req_pc_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      instr_q    <= instr_d;
      pcbuf_q    <= pcbuf_d;
    end
  end

`ifndef SYNTHESIS
  // The issue rule must always leave room for the response it creates.
  assert property (@(posedge clk) disable iff (!rstn)
    !(push && !pop && count_q == DEPTH_CNT));
`endif

endmodule

// File: doc/ifetch_unit.md
# ifetch_unit

Instruction fetch unit between the PC register and the decode stage of the RV32IM pipeline. It consumes the current fetch PC and returns the PC-advance enable to the PC register. It issues word reads to the synchronous instruction memory and buffers returned instructions with their PCs in a small FIFO. It delivers them to decode over a valid/ready handshake and supports pipeline flush on redirect.

## Interface
- `ADDR_W`, 13: byte-address width of the PC.
- `DEPTH`, 2: instruction buffer entries, power of two, ≥2.

- `clk`, in, 1: single clock, rising edge.
- `rstn`, in, 1: asynchronous, active-low reset.
- `pc`, in, ADDR_W: current fetch PC from the PC register.
- `pc_en`, out, 1: enable to the PC register; high means `pc` is consumed or redirected this cycle.
- `flush`, in, 1: redirect from execute; discards everything fetched before it.
- `imem_req`, out, 1: instruction memory read strobe.
- `imem_addr`, out, ADDR_W-2: word address, `pc[ADDR_W-1:2]`.
- `imem_rdata`, in, 32: read data, valid exactly one cycle after `imem_req`.
- `id_valid`, out, 1: buffer head is valid.
- `id_ready`, in, 1: decode accepts the head.
- `id_instr`, out, 32: head instruction.
- `id_pc`, out, ADDR_W: PC of the head instruction.
- `id_fault`, out, 1: head is an instruction-address-misaligned fault.

## Operation
- State:
  - `inflight` (1 bit) plus captured `req_pc`.
  - FIFO of `DEPTH` entries {instr, pc, fault}, with read/write pointers and `count` (0..DEPTH).
- `pop` = `id_valid & id_ready`.
- `id_valid` = (`count` != 0); `id_instr`, `id_pc` and `id_fault` come from the FIFO head.
- Issue rule:
  - `imem_req` = `!flush & ((count + inflight) < DEPTH | ((count + inflight) == DEPTH & pop))`.
  - `imem_req` is held 0 while `rstn` is low.
- `pc_en` = `imem_req | flush`. On flush the PC register must be allowed to load the redirect target.
- On issue: `inflight` is set to 1 and `req_pc` is set to `pc`. Otherwise `inflight` is set to 0.
- Response cycle (`inflight`=1, no `flush`): push {`imem_rdata`, `req_pc`, fault} into the FIFO.
- Flush cycle:
  - `count` is cleared to 0 and both pointers reset.
  - Any response arriving in this cycle is dropped.
  - `inflight` is set to 0 and no request is issued.
  - `pop` in a flush cycle has no effect beyond the clear.
- Simultaneous push and pop: `count` is unchanged and both pointers advance.
- Pointers wrap modulo `DEPTH`.
- The FIFO never overflows, because the issue rule guarantees space. Overflow is a verification assertion.
- Reset mid-operation: all state clears asynchronously and in-flight data is lost.

## Timing
- Reset values: `pc_en`=0, `imem_req`=0, `id_valid`=0, `id_fault`=0, `id_instr`=0, `id_pc`=0, `inflight`=0, `count`=0.
- A request issued in cycle t has its data on `imem_rdata` in t+1. The FIFO is written at the end of t+1 and `id_valid` rises in t+2. Fetch-to-decode latency is 2 cycles.
- With `id_ready` held high, steady-state throughput is 1 instruction per cycle for `DEPTH` ≥ 2.
- With `id_ready` low, at most `DEPTH` instructions are held. `pc_en` drops the cycle `count + inflight` reaches `DEPTH` with no pop.
- After `flush` in cycle t, the first request for the target is issued in t+1 and the target instruction reaches `id_valid` in t+3.
- `imem_addr` and `pc_en` are combinational from `pc`, `count`, `inflight`, `flush` and `id_ready`.

## Configuration
- `IFETCH_MISALIGN_TRAP_EN` defined:
  - A request with `pc[1]`=1 sets the entry's fault bit.
  - That entry's instr is forced to 32'h00000013 (NOP).
  - Issue stops after a faulting request until `flush`.
- `IFETCH_MISALIGN_TRAP_EN` not defined:
  - `pc[1]` is ignored, `id_fault` is tied 0, and fetch proceeds from `pc[ADDR_W-1:2]`.

## Test plan
- Reset: hold `rstn` low for 3 cycles with `id_ready`=1 → all outputs are 0; the first `imem_req` occurs in the first cycle after deassertion with `imem_addr`=0.
- Streaming: memory word n = 32'h1000_0000+n, PC advancing 0,4,8,12 with `id_ready`=1 → `id_pc` shows 0,4,8,12 on consecutive cycles starting 2 cycles after the first request, each with matching instr.
- Backpressure: deassert `id_ready` for 4 cycles mid-stream → `pc_en`=0 after 2 buffered entries; on release, the entries pop in order with none lost or duplicated.
- Flush with full buffer and a request in flight: assert `flush` one cycle with `pc` redirected to 0x100 → `id_valid`=0 next cycle; the next delivered `id_pc`=0x100 arrives 3 cycles after flush.
- Misalign (macro defined): `pc`=0x006 → entry with `id_fault`=1 and `id_instr`=32'h00000013; no further `imem_req` until `flush`. Without the macro: `id_fault`=0 and word 1 is returned.
- Reset mid-stream: pulse `rstn` low while `count`=2 and `inflight`=1 → `id_valid` drops immediately and `count`=0 after release.
